// File: rtl/fw_pkg.sv
// Shared definitions for the firmware sequencer, instruction ROM and assembler tables.
package fw_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP  = 4'h0,
    OPC_CALC = 4'h3,
    OPC_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  function automatic logic is_busy(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/fw_watchdog.sv
// Cycle counter with clear/enable; tc flags that TIMEOUT cycles have been spent waiting.
module fw_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'sd1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter; saturates at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (srst || clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && !tc) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == CNT_LAST);

endmodule

// File: rtl/firmware_sequencer.sv
// Firmware control unit: PC/IR, fetch-decode FSM, CALC handshake and fault trapping.
module firmware_sequencer
  import fw_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [$clog2(DEPTH)-1:0]   imem_addr,
  input  logic [WIDTH-1:0]           imem_data,
  output logic                       calc_start,
  output logic [WIDTH-OPC_W-1:0]     calc_arg,
  input  logic                       calc_done,
  output logic                       busy,
  output logic                       halted,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = WIDTH - OPC_W;
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 32'sd1);

  seq_state_e     state_r, state_s;
  logic [AW-1:0]  pc_r, pc_s;
  logic [WIDTH-1:0] ir_r, ir_s;
  logic [OW-1:0]  calc_arg_r, calc_arg_s;
  err_code_e      err_code_r, err_code_s;
  logic           calc_start_r, calc_start_s;
  logic           busy_r, halted_r, err_r;
  logic           wd_clr_s, wd_en_s, wd_tc_s;
  logic [OPC_W-1:0] ir_opc_s, fetch_opc_s;

  assign ir_opc_s    = ir_r[WIDTH-1 -: OPC_W];
  assign fetch_opc_s = imem_data[WIDTH-1 -: OPC_W];

  fw_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .srst   (abort),
    .clear  (wd_clr_s),
    .enable (wd_en_s),
    .tc     (wd_tc_s)
  );

  // Next-state, datapath updates and decode; abort overrides every state.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    ir_s         = ir_r;
    calc_arg_s   = calc_arg_r;
    err_code_s   = err_code_r;
    calc_start_s = 1'b0;
    wd_clr_s     = 1'b0;
    wd_en_s      = 1'b0;
    if (abort) begin
      state_s    = ST_IDLE;
      pc_s       = {AW{1'b0}};
      calc_arg_s = {OW{1'b0}};
      err_code_s = ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_s    = ST_FETCH;
            pc_s       = {AW{1'b0}};
            err_code_s = ERR_NONE;
          end else begin
            state_s = state_r;
          end
        end
        ST_FETCH: begin
          ir_s    = imem_data;
          state_s = ST_EXEC;
          // The pulse is registered here so it lines up with the EXEC cycle.
          calc_start_s = (fetch_opc_s == OPC_CALC);
        end
        ST_EXEC: begin
          case (ir_opc_s)
            OPC_NOP: begin
              if (pc_r == PC_LAST) begin
                err_code_s = ERR_OVERRUN;
                state_s    = ST_ERROR;
              end else begin
                pc_s    = pc_r + AW'(1'b1);
                state_s = ST_FETCH;
              end
            end
            OPC_CALC: begin
              calc_arg_s = ir_r[OW-1:0];
              wd_clr_s   = 1'b1;
              state_s    = ST_WAIT;
            end
            OPC_HALT: begin
              state_s = ST_DONE;
            end
            default: begin
              err_code_s = ERR_ILLEGAL;
              state_s    = ST_ERROR;
            end
          endcase
        end
        ST_WAIT: begin
          if (calc_done) begin
            if (pc_r == PC_LAST) begin
              err_code_s = ERR_OVERRUN;
              state_s    = ST_ERROR;
            end else begin
              pc_s    = pc_r + AW'(1'b1);
              state_s = ST_FETCH;
            end
          end else if (wd_tc_s) begin
            err_code_s = ERR_TIMEOUT;
            state_s    = ST_ERROR;
          end else begin
            wd_en_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= {AW{1'b0}};
      ir_r         <= {WIDTH{1'b0}};
      calc_arg_r   <= {OW{1'b0}};
      err_code_r   <= ERR_NONE;
      calc_start_r <= 1'b0;
      busy_r       <= 1'b0;
      halted_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      ir_r         <= ir_s;
      calc_arg_r   <= calc_arg_s;
      err_code_r   <= err_code_s;
      calc_start_r <= calc_start_s;
      busy_r       <= is_busy(state_s);
      halted_r     <= (state_s == ST_DONE);
      err_r        <= (state_s == ST_ERROR);
    end
  end

  assign imem_addr  = pc_r;
  assign calc_start = calc_start_r;
  assign calc_arg   = calc_arg_r;
  assign busy       = busy_r;
  assign halted     = halted_r;
  assign err        = err_r;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_firmware_sequencer.sv
// Directed bench for firmware_sequencer: table of whole-program runs plus hand-written corner sequences.
module tb_firmware_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  imem_addr;
  logic [15:0] imem_data;
  logic        calc_start;
  logic [11:0] calc_arg;
  logic        calc_done;
  logic        busy;
  logic        halted;
  logic        err;
  logic [1:0]  err_code;

  logic [15:0] rom_mem [4];
  int ncmp;
  int nfail;

  assign imem_data = rom_mem[imem_addr];

  firmware_sequencer #(.WIDTH(16), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .calc_start (calc_start),
    .calc_arg   (calc_arg),
    .calc_done  (calc_done),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rom;
    int lat;
    int exp_cyc;
    int exp_halt;
    int exp_err;
    int exp_code;
    int exp_ncs;
    int exp_arg;
    int exp_addr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_rom(input logic [63:0] r);
    for (int k = 0; k < 4; k++) rom_mem[k] = r[16*k +: 16];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_calc_start"}, int'(calc_start), 0);
    chk({tag, "_imem_addr"}, int'(imem_addr), 0);
    chk({tag, "_calc_arg"}, int'(calc_arg), 0);
  endtask

  // Starts a program from a negedge and runs it until busy drops, answering CALCs after lat cycles.
  task automatic run_vec(input int lat, output int cyc, output int ncs);
    int done_at;
    done_at = -1;
    cyc = 0;
    ncs = 0;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      calc_done = 1'b0;
      if (calc_start) begin
        ncs++;
        if (lat > 0) done_at = i + lat;
      end
      if (!busy) begin
        cyc = i;
        break;
      end
      if (i == done_at) calc_done = 1'b1;
      @(posedge clk);
    end
    calc_done = 1'b0;
  endtask

  initial begin
    int cyc;
    int ncs;
    int exp_trace [6];
    ncmp = 0;
    nfail = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    calc_done = 1'b0;
    load_rom(64'h0);

    //                rom                      lat cyc halt err code ncs arg      addr
    vecs[0] = '{64'h0000_0000_F000_3003, 5, 10, 1, 0, 0, 1, 12'h003, 1};
    vecs[1] = '{64'h0000_0000_0000_7000, 0,  3, 0, 1, 1, 0, 12'h003, 0};
    vecs[2] = '{64'h0000_F000_0000_0000, 0,  7, 1, 0, 0, 0, 12'h003, 2};
    vecs[3] = '{64'h0000_0000_F000_302A, 0, 11, 0, 1, 3, 1, 12'h02A, 0};
    vecs[4] = '{64'h0000_F000_3FFF_0000, 8, 15, 1, 0, 0, 1, 12'hFFF, 2};
    vecs[5] = '{64'h0000_0000_0000_0000, 0,  9, 0, 1, 2, 0, 12'hFFF, 3};
    vecs[6] = '{64'hF000_0000_0000_0000, 0,  9, 1, 0, 0, 0, 12'hFFF, 3};
    vecs[7] = '{64'h3005_0000_0000_0000, 2, 11, 0, 1, 2, 1, 12'h005, 3};
    vecs[8] = '{64'h0000_F000_3123_3ABC, 1,  9, 1, 0, 0, 2, 12'h123, 2};

    tick();
    tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      load_rom(vecs[v].rom);
      run_vec(vecs[v].lat, cyc, ncs);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_halted", v), int'(halted), vecs[v].exp_halt);
      chk($sformatf("v%0d_err", v), int'(err), vecs[v].exp_err);
      chk($sformatf("v%0d_err_code", v), int'(err_code), vecs[v].exp_code);
      chk($sformatf("v%0d_calc_starts", v), ncs, vecs[v].exp_ncs);
      chk($sformatf("v%0d_calc_arg", v), int'(calc_arg), vecs[v].exp_arg);
      chk($sformatf("v%0d_imem_addr", v), int'(imem_addr), vecs[v].exp_addr);
      tick();
    end

    // Address trace of {NOP, NOP, HALT}: each PC is presented for FETCH and EXEC.
    exp_trace = '{0, 0, 1, 1, 2, 2};
    load_rom(64'h0000_F000_0000_0000);
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("trace%0d_imem_addr", i + 1), int'(imem_addr), exp_trace[i]);
      chk($sformatf("trace%0d_calc_start", i + 1), int'(calc_start), 0);
    end
    tick();
    chk("trace7_halted", int'(halted), 1);

    // Start while busy is ignored, then abort in WAIT and ignore a stray calc_done.
    load_rom(64'h0000_0000_F000_3005);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    tick();
    chk("abort_calc_start_exec", int'(calc_start), 1);
    tick();
    chk("abort_calc_arg_wait", int'(calc_arg), 5);
    chk("abort_busy_wait", int'(busy), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_busy", int'(busy), 1);
    tick();
    chk("busy_start_no_restart", int'(calc_start), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    tick();
    chk_idle("abort_done_ignored");

    // Reset dropped mid-FETCH of a CALC: the pending calc_start must not appear.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("rstmid_busy_fetch", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_idle("rstmid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("rstmid_held");
    tick();
    chk_idle("rstmid_release");
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    tick();
    chk_idle("rstmid_done_ignored");

    // Normal operation resumes after reset.
    load_rom(vecs[0].rom);
    run_vec(vecs[0].lat, cyc, ncs);
    chk("recover_cycles", cyc, 10);
    chk("recover_halted", int'(halted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
